// File: rtl/tap_change_fifo.sv
// Change-detecting tap capture feeding a small valid/ready FIFO with saturating drop count.
// Optional per-entry cycle timestamp on out_ts when TAP_CHANGE_FIFO_TIMESTAMP_EN is defined.
module tap_change_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       tap_value,
    input  logic                    tap_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [$clog2(DEPTH):0]  out_level,
    output logic [7:0]              drop_cnt
`ifdef TAP_CHANGE_FIFO_TIMESTAMP_EN
    ,
    output logic [15:0]             out_ts
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned TS_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_n;
    logic                capture;
    logic [DATA_W-1:0]   last_q;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_inc;
    logic [LVL_W-1:0]    level_n;
    logic [DATA_W-1:0]   head_data_n;
    logic                full;
    logic                pop;
    logic                push;
    logic                drop;
    logic                head_from_input;

    // Capture FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state and capture decision; leaving TRACK never captures
    always_comb begin
        state_n = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (tap_en) begin
                    state_n = ARM;
                end
            end
            ARM: begin
                capture = 1'b1;
                state_n = tap_en ? TRACK : IDLE;
            end
            TRACK: begin
                if (!tap_en) begin
                    state_n = IDLE;
                end else if (tap_value != last_q) begin
                    capture = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Last-captured value follows every capture attempt, dropped or not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (capture) begin
            last_q <= tap_value;
        end
    end

    assign full       = (out_level == LVL_W'(DEPTH));
    assign pop        = out_valid & out_ready;
    assign push       = capture & (~full | pop);
    assign drop       = capture & full & ~pop;
    assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

    always_comb begin
        level_n = out_level;
        case ({push, pop})
            2'b10:   level_n = out_level + LVL_W'(1);
            2'b01:   level_n = out_level - LVL_W'(1);
            default: level_n = out_level;
        endcase
    end

    // Head after this edge: newly pushed entry when the FIFO is (or drains to) empty
    assign head_from_input = (out_level == '0) || (pop && (out_level == LVL_W'(1)));

    always_comb begin
        head_data_n = out_data;
        if (head_from_input) begin
            if (push) begin
                head_data_n = tap_value;
            end
        end else if (pop) begin
            head_data_n = mem[rd_ptr_inc];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= tap_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            out_level <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_inc;
            end
            out_level <= level_n;
            out_valid <= (level_n != '0);
            out_data  <= head_data_n;
        end
    end

    // Drop counter saturates rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef TAP_CHANGE_FIFO_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] ts_stamp;
    logic [TS_W-1:0] ts_mem [DEPTH];
    logic [TS_W-1:0] head_ts_n;

    // Stamp equals the cycle count reached on the sampling edge
    assign ts_stamp = ts_q + TS_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_stamp;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_ptr_q] <= ts_stamp;
        end
    end

    always_comb begin
        head_ts_n = out_ts;
        if (head_from_input) begin
            if (push) begin
                head_ts_n = ts_stamp;
            end
        end else if (pop) begin
            head_ts_n = ts_mem[rd_ptr_inc];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ts <= '0;
        end else begin
            out_ts <= head_ts_n;
        end
    end
`endif

endmodule

// File: tb/tb_tap_change_fifo.sv
// Directed bench for tap_change_fifo: scoreboard of expected captures checked on each handshake.
module tb_tap_change_fifo;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] tap_value;
    logic              tap_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        out_level;
    logic [7:0]        drop_cnt;
`ifdef TAP_CHANGE_FIFO_TIMESTAMP_EN
    logic [15:0]       out_ts;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [$];

    tap_change_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tap_value (tap_value),
        .tap_en    (tap_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_level (out_level),
        .drop_cnt  (drop_cnt)
`ifdef TAP_CHANGE_FIFO_TIMESTAMP_EN
        ,
        .out_ts    (out_ts)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check any handshake at the falling edge, then advance past the next rising edge
    task automatic step();
        logic [7:0] want;
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("pop_has_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                want = sb.pop_front();
                chk("pop_data", 32'(out_data), 32'(want));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        tap_en    = 1'b0;
        tap_value = '0;
        out_ready = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_level", 32'(out_level), 32'd0);
        chk("rst_drop",  32'(drop_cnt),  32'd0);

        // Constant value held: a single capture
        out_ready = 1'b1;
        step();
        tap_en = 1'b1;
        tap_value = 8'h05;
        step();
        sb.push_back(8'h05);
        step();
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data",  32'(out_data),  32'h05);
`ifdef TAP_CHANGE_FIFO_TIMESTAMP_EN
        chk("hold_ts", 32'(out_ts), 32'd3);
`endif
        for (int i = 0; i < 9; i++) step();
        chk("hold_one_output", 32'(sb.size()), 32'd0);
        chk("hold_idle_valid", 32'(out_valid), 32'd0);
        chk("hold_drop",       32'(drop_cnt),  32'd0);

        // Ramp with consumer always ready
        do_reset();
        out_ready = 1'b1;
        tap_en = 1'b1;
        tap_value = 8'h00;
        step();
        for (int i = 0; i < 10; i++) begin
            tap_value = 8'(i);
            sb.push_back(8'(i));
            step();
            chk("ramp_valid", 32'(out_valid), 32'd1);
            chk("ramp_head",  32'(out_data),  32'(i));
        end
        tap_en = 1'b0;
        tap_value = 8'h77;
        step();
        step();
        chk("ramp_drained",  32'(sb.size()), 32'd0);
        chk("ramp_no_exit_capture", 32'(out_valid), 32'd0);

        // Fill with consumer stalled, overflow by two
        do_reset();
        tap_en = 1'b1;
        tap_value = 8'h10;
        step();
        for (int i = 0; i < 6; i++) begin
            tap_value = 8'(8'h10 + i);
            if (i < 4) sb.push_back(8'(8'h10 + i));
            step();
        end
        chk("full_level", 32'(out_level), 32'd4);
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_head",  32'(out_data),  32'h10);
        chk("full_drop",  32'(drop_cnt),  32'd2);

        // Simultaneous pop and push while full
        tap_value = 8'h20;
        out_ready = 1'b1;
        sb.push_back(8'h20);
        step();
        out_ready = 1'b0;
        chk("fullpp_level", 32'(out_level), 32'd4);
        chk("fullpp_drop",  32'(drop_cnt),  32'd2);
        chk("fullpp_head",  32'(out_data),  32'h11);
        step();
        chk("stall_head_stable", 32'(out_data), 32'h11);

        // Saturate the drop counter
        for (int i = 0; i < 300; i++) begin
            tap_value = (i % 2 == 0) ? 8'h30 : 8'h31;
            step();
        end
        chk("sat_drop",  32'(drop_cnt),  32'd255);
        chk("sat_level", 32'(out_level), 32'd4);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_data",  32'(out_data),  32'd0);
        chk("async_level", 32'(out_level), 32'd0);
        chk("async_drop",  32'(drop_cnt),  32'd0);
        sb.delete();
        step();
        tap_value = 8'h3C;
        step();
        chk("in_reset_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tap_value = 8'h44;
        step();
        chk("post_rst_arm_valid", 32'(out_valid), 32'd0);
        chk("post_rst_arm_level", 32'(out_level), 32'd0);
        sb.push_back(8'h44);
        step();
        chk("post_rst_data",  32'(out_data),  32'h44);
        chk("post_rst_level", 32'(out_level), 32'd1);
        tap_en = 1'b0;
        step();
        step();
        chk("final_drained", 32'(sb.size()), 32'd0);
        chk("final_valid",   32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
